// File: rtl/keypad_msg_uart_tx.sv
// keypad_msg_uart_tx
// Sends the 16-byte keypad message over an 8N1 UART line, first byte first.
// Null padding bytes are skipped. A one-cycle done pulse marks the end of the message.
`timescale 1ns/1ps
module keypad_msg_uart_tx #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic [127:0] msg,
    input  logic         msg_tx_ctrl,
    output logic         tx,
    output logic         busy,
    output logic         done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEEK,
        START,
        DATA,
        STOP
    } stateT;

    stateT              r_state;
    logic [127:0]       r_shadow;
    logic [4:0]         r_idx;
    logic [7:0]         r_shift;
    logic [2:0]         r_bitCnt;
    logic [BAUD_W-1:0]  r_baudCnt;
    logic               r_tx;
    logic               r_done;

    logic [7:0]         w_curByte;
    logic               w_bitEnd;

    // Pick the latched byte addressed by the current index; index 16 reads as null.
    always_comb begin
        w_curByte = 8'h00;
        for (int i = 0; i < 16; i++) begin
            if (r_idx == 5'(i)) begin
                w_curByte = r_shadow[127 - 8*i -: 8];
            end
        end
    end

    assign w_bitEnd = (r_baudCnt == BAUD_LAST);

    // Message sequencer: latch, skip nulls, and shift out start/data/stop bits.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state   <= IDLE;
            r_shadow  <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_bitCnt  <= '0;
            r_baudCnt <= '0;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (msg_tx_ctrl) begin
                        r_shadow <= msg;
                        r_idx    <= 5'd0;
                        r_state  <= SEEK;
                    end
                end
                SEEK: begin
                    if (r_idx == 5'd16) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end else if (w_curByte == 8'h00) begin
                        r_idx <= r_idx + 5'd1;
                    end else begin
                        r_shift   <= w_curByte;
                        r_baudCnt <= '0;
                        r_tx      <= 1'b0;
                        r_state   <= START;
                    end
                end
                START: begin
                    if (w_bitEnd) begin
                        r_baudCnt <= '0;
                        r_tx      <= r_shift[0];
                        r_bitCnt  <= 3'd0;
                        r_state   <= DATA;
                    end else begin
                        r_baudCnt <= r_baudCnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bitEnd) begin
                        r_baudCnt <= '0;
                        r_shift   <= {1'b0, r_shift[7:1]};
                        if (r_bitCnt == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bitCnt <= r_bitCnt + 3'd1;
                            r_tx     <= r_shift[1];
                        end
                    end else begin
                        r_baudCnt <= r_baudCnt + 1'b1;
                    end
                end
                STOP: begin
                    if (w_bitEnd) begin
                        r_baudCnt <= '0;
                        r_idx     <= r_idx + 5'd1;
                        r_state   <= SEEK;
                    end else begin
                        r_baudCnt <= r_baudCnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tx   = r_tx;
    assign done = r_done;
    assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_keypad_msg_uart_tx.sv
// tb_keypad_msg_uart_tx
// Self-checking bench: a cycle-level expectation queue built from the message
// contents is compared with tx/busy/done every cycle, plus literal frame checks.
`timescale 1ns/1ps
module tb_keypad_msg_uart_tx;

    localparam int C = 4;

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic [127:0] msg = '0;
    logic         msg_tx_ctrl = 1'b0;
    logic         tx;
    logic         busy;
    logic         done;

    keypad_msg_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk         (clk),
        .nrst        (nrst),
        .msg         (msg),
        .msg_tx_ctrl (msg_tx_ctrl),
        .tx          (tx),
        .busy        (busy),
        .done        (done)
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    int         assertCount = 0;
    int         failCount = 0;
    bit         checkEnable = 1'b0;
    bit         modelIdle;
    logic [2:0] cmpExp;

    // Expected {tx, busy, done} for the current and upcoming cycles.
    logic [2:0] expQ[$];

    bit         traceTx[$];
    bit         traceBusy[$];
    bit         traceDone[$];
    int         frameStart[$];
    logic [7:0] frameByte[$];
    bit         frameStop[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        assertCount++;
        if (actual !== required) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, required, $time);
        end
    endtask

    // Expand one message into its per-cycle line/busy/done expectation.
    task automatic pushMessage(input logic [127:0] m);
        logic [7:0] b;
        bit         lvl;
        for (int i = 0; i < 16; i++) begin
            b = m[127 - 8*i -: 8];
            expQ.push_back(3'b110);
            if (b != 8'h00) begin
                for (int s = 0; s < 10; s++) begin
                    if (s == 0) lvl = 1'b0;
                    else if (s == 9) lvl = 1'b1;
                    else lvl = b[s-1];
                    repeat (C) expQ.push_back({lvl, 2'b10});
                end
            end
        end
        expQ.push_back(3'b110);
        expQ.push_back(3'b101);
    endtask

    // Reference model: advance one cycle per edge, accept requests only when not busy.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            expQ.delete();
        end else begin
            modelIdle = (expQ.size() == 0) || (expQ[0][1] == 1'b0);
            if (expQ.size() > 0) void'(expQ.pop_front());
            if (modelIdle && msg_tx_ctrl) pushMessage(msg);
        end
    end

    // Per-cycle comparison of the DUT outputs against the model.
    always @(negedge clk) begin
        if (checkEnable && nrst) begin
            cmpExp = (expQ.size() == 0) ? 3'b100 : expQ[0];
            checkOutput("cycle tx/busy/done", {29'd0, tx, busy, done}, {29'd0, cmpExp});
        end
    end

    task automatic applyStimulus(input logic [127:0] m);
        @(negedge clk);
        msg = m;
        msg_tx_ctrl = 1'b1;
        @(negedge clk);
        msg_tx_ctrl = 1'b0;
    endtask

    // Record outputs from the first SEEK cycle up to the done cycle.
    task automatic captureMessage(input int disturbAt, input logic [127:0] junk, input int abortAt,
                                  input bit chain, input logic [127:0] nextMsg);
        int k;
        bit seenDone;
        k = 0;
        seenDone = 1'b0;
        traceTx.delete();
        traceBusy.delete();
        traceDone.delete();
        while (!seenDone && k < 3000) begin
            traceTx.push_back(tx);
            traceBusy.push_back(busy);
            traceDone.push_back(done);
            if (k == abortAt) break;
            if (done) begin
                seenDone = 1'b1;
                if (chain) begin
                    msg = nextMsg;
                    msg_tx_ctrl = 1'b1;
                    @(negedge clk);
                    msg_tx_ctrl = 1'b0;
                end
            end else begin
                if (k == disturbAt) begin
                    msg = junk;
                    msg_tx_ctrl = 1'b1;
                end else if (k == disturbAt + 1) begin
                    msg_tx_ctrl = 1'b0;
                end
                @(negedge clk);
                k++;
            end
        end
        msg_tx_ctrl = 1'b0;
        if (abortAt < 0) checkOutput("done within budget", {31'd0, seenDone}, 32'd1);
    endtask

    // Plain UART receiver over the recorded line: sample mid-bit after each start edge.
    task automatic decodeTrace();
        int         k;
        logic [7:0] b;
        frameStart.delete();
        frameByte.delete();
        frameStop.delete();
        k = 0;
        while (k < traceTx.size()) begin
            if (traceTx[k] == 1'b0 && k + 10*C <= traceTx.size()) begin
                for (int j = 0; j < 8; j++) b[j] = traceTx[k + C*(j+1) + C/2];
                frameStart.push_back(k);
                frameByte.push_back(b);
                frameStop.push_back(traceTx[k + 9*C + C/2]);
                k += 10*C;
            end else begin
                k++;
            end
        end
    endtask

    function automatic int countBusy();
        int n = 0;
        foreach (traceBusy[i]) n += int'(traceBusy[i]);
        return n;
    endfunction

    function automatic int countDone();
        int n = 0;
        foreach (traceDone[i]) n += int'(traceDone[i]);
        return n;
    endfunction

    task automatic checkFrames(input string name, input int n, input int starts[3],
                               input logic [7:0] bytes[3], input int busyExp);
        decodeTrace();
        checkOutput({name, " frame count"}, frameStart.size(), n);
        for (int f = 0; f < n && f < frameStart.size(); f++) begin
            checkOutput({name, " frame start"}, frameStart[f], starts[f]);
            checkOutput({name, " frame byte"}, {24'd0, frameByte[f]}, {24'd0, bytes[f]});
            checkOutput({name, " stop bit"}, {31'd0, frameStop[f]}, 32'd1);
        end
        checkOutput({name, " busy cycles"}, countBusy(), busyExp);
        checkOutput({name, " done pulses"}, countDone(), 1);
    endtask

    // Single '9' in the last byte: 16 idle SEEK cycles then one fixed frame.
    task automatic checkNine();
        bit [9:0] pat;
        bit [3:0] seg;
        pat = 10'b1001110010;
        checkFrames("nine", 1, '{16, 0, 0}, '{8'h39, 8'h00, 8'h00}, 57);
        for (int j = 0; j < 10; j++) begin
            for (int c = 0; c < 4; c++) seg[c] = traceTx[16 + 4*j + c];
            checkOutput("nine line symbol", {28'd0, seg}, {28'd0, {4{pat[j]}}});
        end
    endtask

    function automatic logic [127:0] randomMsg();
        logic [127:0] m;
        for (int i = 0; i < 16; i++) begin
            m[127 - 8*i -: 8] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
        end
        return m;
    endfunction

    // Hard stop in case something stalls the main sequence.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Main sequence: directed scenarios, then randomized messages.
    initial begin
        logic [127:0] m;
        logic [127:0] nm;
        logic [7:0]   expBytes[$];
        bit           chained;
        bit           nextChain;

        repeat (3) @(negedge clk);
        checkOutput("reset tx", {31'd0, tx}, 32'd1);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        nrst = 1'b1;
        checkEnable = 1'b1;
        repeat (2) @(negedge clk);

        @(posedge clk);
        #2 nrst = 1'b0;
        #1;
        checkOutput("async reset idle tx", {31'd0, tx}, 32'd1);
        checkOutput("async reset idle busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        nrst = 1'b1;

        $display("[TB] all-null message");
        applyStimulus(128'h0);
        captureMessage(-1, '0, -1, 1'b0, '0);
        checkFrames("null msg", 0, '{0, 0, 0}, '{8'h00, 8'h00, 8'h00}, 17);

        $display("[TB] single byte 9");
        applyStimulus({120'h0, 8'h39});
        captureMessage(-1, '0, -1, 1'b0, '0);
        checkNine();

        $display("[TB] 911 with ignored request and back-to-back message");
        applyStimulus({24'h393131, 104'h0});
        captureMessage(10, {16{8'h55}}, -1, 1'b1, {8'h42, 120'h0});
        checkFrames("911", 3, '{1, 42, 83}, '{8'h39, 8'h31, 8'h31}, 137);
        captureMessage(-1, '0, -1, 1'b0, '0);
        checkFrames("chained B", 1, '{1, 0, 0}, '{8'h42, 8'h00, 8'h00}, 57);

        $display("[TB] interior nulls");
        applyStimulus({8'h41, 8'h00, 8'h00, 8'h42, 96'h0});
        captureMessage(-1, '0, -1, 1'b0, '0);
        checkFrames("interior nulls", 2, '{1, 44, 0}, '{8'h41, 8'h42, 8'h00}, 97);

        $display("[TB] reset mid-frame");
        applyStimulus({8'h30, 120'h0});
        captureMessage(-1, '0, 18, 1'b0, '0);
        checkOutput("abort data bit low", {31'd0, traceTx[18]}, 32'd0);
        #3 nrst = 1'b0;
        #1;
        checkOutput("abort tx high", {31'd0, tx}, 32'd1);
        checkOutput("abort busy low", {31'd0, busy}, 32'd0);
        checkOutput("abort done low", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        applyStimulus({120'h0, 8'h39});
        captureMessage(-1, '0, -1, 1'b0, '0);
        checkNine();

        $display("[TB] randomized messages");
        chained = 1'b0;
        m = randomMsg();
        for (int it = 0; it < 25; it++) begin
            if (!chained) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                applyStimulus(m);
            end
            nextChain = (it < 24) ? 1'($urandom_range(0, 1)) : 1'b0;
            nm = randomMsg();
            captureMessage($urandom_range(1, 15), {$urandom(), $urandom(), $urandom(), $urandom()},
                           -1, nextChain, nm);
            decodeTrace();
            expBytes.delete();
            for (int i = 0; i < 16; i++) begin
                if (m[127 - 8*i -: 8] != 8'h00) expBytes.push_back(m[127 - 8*i -: 8]);
            end
            checkOutput("random frame count", frameStart.size(), expBytes.size());
            for (int f = 0; f < expBytes.size() && f < frameByte.size(); f++) begin
                checkOutput("random frame byte", {24'd0, frameByte[f]}, {24'd0, expBytes[f]});
            end
            checkOutput("random busy cycles", countBusy(), 17 + 10*C*expBytes.size());
            m = nm;
            chained = nextChain;
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/keypad_msg_uart_tx.md
# keypad_msg_uart_tx

Serializes the 128-bit message produced by `keypad_control` (16 ASCII bytes) onto an 8N1 UART line for the host/terminal. The block sits directly downstream of `keypad_control`. It latches `msg` on the `msg_tx_ctrl` pulse, skips null (0x00) padding bytes, and transmits the remaining bytes MSB-byte-first. It signals completion with a one-cycle `done` pulse.

## Interface
- `CLKS_PER_BIT`, default 87: clock cycles per UART bit (10 MHz / 115200). Must be ≥ 2.
- `clk` input 1: system clock; all state updates on rising edge.
- `nrst` input 1: reset, asynchronous, active-low.
- `msg` input 128: message; byte i = `msg[127-8i -: 8]`, i = 0..15, sent in order i = 0 first.
- `msg_tx_ctrl` input 1: start request from `keypad_control`; sampled only in IDLE.
- `tx` output 1: UART serial data, idle high; registered.
- `busy` output 1: high while a message is in progress (state ≠ IDLE).
- `done` output 1: one-cycle pulse when a message finishes; registered.

## Operation
- Internal registers:
  - `shadow[127:0]`: latched message.
  - `idx[4:0]`: byte index, 0..16.
  - `shift[7:0]`
  - `bitcnt[2:0]`
  - `baudcnt`: `$clog2(CLKS_PER_BIT)` bits.
- States: IDLE, SEEK, START, DATA, STOP.
- IDLE: `tx`=1, `busy`=0.
  - On `msg_tx_ctrl`=1: `shadow`←`msg`, `idx`←0, go to SEEK.
- SEEK: one cycle per index.
  - `idx`==16: `done`←1, go to IDLE.
  - byte[`idx`]==0x00: `idx`←`idx`+1, stay in SEEK.
  - Otherwise: `shift`←byte[`idx`], `baudcnt`←0, `tx`←0, go to START.
- START: hold `tx`=0 for `CLKS_PER_BIT` cycles.
  - Then `tx`←`shift[0]`, `bitcnt`←0, go to DATA.
- DATA: each bit is held `CLKS_PER_BIT` cycles, LSB first.
  - At end of bit: shift right.
  - If `bitcnt`==7: `tx`←1, go to STOP. Else `bitcnt`++ and `tx`←next bit.
- STOP: hold `tx`=1 for `CLKS_PER_BIT` cycles.
  - Then `idx`←`idx`+1, go to SEEK.
- `baudcnt` counts 0..`CLKS_PER_BIT`-1 and wraps to 0 at each bit boundary.
- `msg_tx_ctrl` is ignored in every state except IDLE; no queuing.
- `msg` changes after the latch cycle have no effect on the message in flight.
- A null byte is never transmitted, regardless of its position in the message.

## Timing
- Reset (`nrst`=0, any time, asynchronous) gives:
  - state=IDLE, `tx`=1, `busy`=0, `done`=0.
  - `shadow`, `idx`, `shift`, `bitcnt`, `baudcnt` all = 0.
- Reset mid-frame aborts the frame immediately; `tx` returns high with no glitch low.
- Start latency: `msg_tx_ctrl` sampled at edge N (IDLE). SEEK runs at N+1.
  - If byte 0 ≠ 0, `tx` falls after edge N+1.
  - Each leading null byte adds 1 cycle.
- Frame length is exactly 10·`CLKS_PER_BIT` cycles: 1 start + 8 data + 1 stop.
- Every index (0..15) costs one SEEK cycle, plus one final SEEK at `idx`==16.
- `busy` is high for exactly 17 + 10·`CLKS_PER_BIT`·k cycles, where k = number of non-null bytes.
- `done` is high for the single cycle after the final SEEK. In that cycle `busy`=0 and state=IDLE.
- A `msg_tx_ctrl` in the `done` cycle is accepted (back-to-back messages).
- There is no idle gap between frames beyond the SEEK cycles. Null bytes between frames lengthen the high level.

## Test plan
Benches use `CLKS_PER_BIT`=4.
1. Reset:
   - Assert `nrst`=0 asynchronously mid-cycle → `tx`=1, `busy`=0, `done`=0 immediately.
   - Release, then pulse `msg_tx_ctrl` with `msg`=0 → `busy` high 17 cycles, no `tx` low, `done` one pulse.
2. Single byte '9':
   - Stimulus: `msg`={120'h0, 8'h39}.
   - `tx` low for the first time 16 cycles after the SEEK entry.
   - Line sequence (4 cycles each): 0,1,0,0,1,1,1,0,0,1.
   - `busy` = 57 cycles; `done` one pulse.
3. "911" left-aligned:
   - Stimulus: `msg`={24'h393131, 104'h0}.
   - Frames carry 0x39, 0x31, 0x31 in order.
   - Exactly 1 high SEEK cycle between frames; `busy` = 137 cycles.
4. Interior nulls:
   - Stimulus: `msg`={8'h41, 8'h00, 8'h00, 8'h42, 96'h0}.
   - Only 0x41 and 0x42 are sent.
   - Gap between the end of the 'A' stop bit and the 'B' start bit = 3 cycles.
5. Ignore while busy:
   - Pulse `msg_tx_ctrl` and change `msg` mid-DATA → original frames unaffected, no restart.
   - Pulse again in the `done` cycle → new message accepted; `tx` falls the cycle after its first SEEK.
6. Reset mid-frame:
   - Drop `nrst` during the 4th data bit → `tx`=1 and `busy`=0 at once.
   - After release, a new '9' message is sent correctly per scenario 2.
